// File: rtl/puf_eval_ctrl.sv
// Challenge sequencer for a single-bit arbiter PUF: walks seed+k challenges,
// waits for each to settle, majority-votes N_VOTE samples into resp_data[k].
`timescale 1ns/1ps
module puf_eval_ctrl #(
  parameter int N_CB   = 64,
  parameter int N_RESP = 32,
  parameter int SETTLE = 4,
  parameter int N_VOTE = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_CB-1:0]   seed,
  output logic              busy,
  output logic [N_CB-1:0]   puf_challenge,
  input  logic              puf_response,
  output logic [N_RESP-1:0] resp_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [2:0]        dbg_state
);

  // Result handshake: resp_data is offered while resp_valid=1 and is consumed
  // on any rising edge where resp_valid && resp_ready; resp_ready is ignored
  // otherwise, and start is only honoured in IDLE.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SAMPLE = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int K_W = (N_RESP > 1) ? $clog2(N_RESP) : 1;
  localparam int S_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int V_W = $clog2(N_VOTE + 1);

  localparam logic [K_W-1:0] K_LAST = K_W'(N_RESP - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(SETTLE - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(N_VOTE - 1);
  localparam logic [V_W-1:0] V_HALF = V_W'(N_VOTE / 2);

  state_t         state;
  state_t         state_nxt;
  logic [K_W-1:0] bit_idx;
  logic [S_W-1:0] settle_cnt;
  logic [V_W-1:0] vote_cnt;
  logic [V_W-1:0] ones_cnt;

  logic load_seed;
  logic settle_inc;
  logic vote_clr;
  logic sample_en;
  logic commit_bit;
  logic step_next;
  logic majority;

  assign majority   = (ones_cnt > V_HALF);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);
  assign dbg_state  = state;

  always_comb begin
    state_nxt  = state;
    load_seed  = 1'b0;
    settle_inc = 1'b0;
    vote_clr   = 1'b0;
    sample_en  = 1'b0;
    commit_bit = 1'b0;
    step_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_seed = 1'b1;
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        if (settle_cnt == S_LAST) begin
          vote_clr  = 1'b1;
          state_nxt = SAMPLE;
        end else begin
          settle_inc = 1'b1;
        end
      end
      SAMPLE: begin
        sample_en = 1'b1;
        if (vote_cnt == V_LAST) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        commit_bit = 1'b1;
        if (bit_idx == K_LAST) begin
          state_nxt = DONE;
        end else begin
          step_next = 1'b1;
          state_nxt = APPLY;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      puf_challenge <= '0;
      resp_data     <= '0;
      bit_idx       <= '0;
      settle_cnt    <= '0;
      vote_cnt      <= '0;
      ones_cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (load_seed) begin
        puf_challenge <= seed;
        resp_data     <= '0;
        bit_idx       <= '0;
        settle_cnt    <= '0;
      end
      if (settle_inc) begin
        settle_cnt <= settle_cnt + S_W'(1);
      end
      if (vote_clr) begin
        vote_cnt <= '0;
        ones_cnt <= '0;
      end
      if (sample_en) begin
        vote_cnt <= vote_cnt + V_W'(1);
        ones_cnt <= ones_cnt + V_W'(puf_response);
      end
      if (commit_bit) begin
        resp_data[bit_idx] <= majority;
      end
      // Challenge wraps naturally modulo 2^N_CB.
      if (step_next) begin
        bit_idx       <= bit_idx + K_W'(1);
        puf_challenge <= puf_challenge + N_CB'(1);
        settle_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl: behavioural PUF (challenge[10]) plus a
// scripted vote stub, checking results, latency, handshake and reset abort.
`timescale 1ns/1ps
module tb_puf_eval_ctrl;

  localparam int N_CB    = 64;
  localparam int N_RESP  = 32;
  localparam int RUN_CYC = 320;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [N_CB-1:0]   seed;
  logic              busy;
  logic [N_CB-1:0]   puf_challenge;
  logic              puf_response;
  logic [N_RESP-1:0] resp_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [2:0]        dbg_state;

  logic stub_mode;
  logic stub_bit;

  int n_checks = 0;
  int n_errors = 0;
  logic [N_RESP-1:0] exp_q[$];
  logic [N_RESP-1:0] cur_exp;
  int cyc;

  assign puf_response = stub_mode ? stub_bit : puf_challenge[10];

  puf_eval_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .seed         (seed),
    .busy         (busy),
    .puf_challenge(puf_challenge),
    .puf_response (puf_response),
    .resp_data    (resp_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_start(input logic [N_CB-1:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seed  = ~s;
    check("start_busy", 64'(busy), 64'd1);
    check("start_chal", puf_challenge, s);
    check("start_clr", 64'(resp_data), 64'd0);
  endtask

  task automatic wait_valid(input logic [N_CB-1:0] s, input bit chk_steps,
                            input bit inject, output int n);
    n = 0;
    while (!resp_valid && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      start      = inject && (n == 55);
      seed       = (inject && n == 55) ? 64'h0 : seed;
      resp_ready = inject && (n == 57);
      if (chk_steps && n < RUN_CYC && (n % 10 == 0 || n % 10 == 9))
        check("chal_step", puf_challenge, s + 64'(n / 10));
    end
    start      = 1'b0;
    resp_ready = 1'b0;
    check("valid_rise", 64'(resp_valid), 64'd1);
  endtask

  task automatic check_result();
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'(exp_q.size()), 64'd1);
      cur_exp = '0;
    end else begin
      cur_exp = exp_q.pop_front();
      check("resp_data", 64'(resp_data), 64'(cur_exp));
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("hs_valid", 64'(resp_valid), 64'd0);
    check("hs_busy", 64'(busy), 64'd0);
    check("hs_data", 64'(resp_data), 64'(cur_exp));
  endtask

  initial begin
    logic [4:0] pat;
    int m;
    int k;
    rst_n      = 1'b0;
    start      = 1'b0;
    seed       = '0;
    resp_ready = 1'b0;
    stub_mode  = 1'b0;
    stub_bit   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_data", 64'(resp_data), 64'd0);
    check("rst_chal", puf_challenge, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: seed 0, exact latency, then backpressure
    exp_q.push_back(32'h0000_0000);
    do_start(64'h0);
    wait_valid(64'h0, 1'b0, 1'b0, cyc);
    check("latency_basic", 64'(cyc), 64'(RUN_CYC));
    check_result();
    for (int i = 0; i < 50; i++) begin
      start = (i == 20);
      seed  = (i == 20) ? 64'h123 : seed;
      @(posedge clk);
      #1;
      if (i % 10 == 9) begin
        check("bp_valid", 64'(resp_valid), 64'd1);
        check("bp_data", 64'(resp_data), 64'(cur_exp));
      end
    end
    start = 1'b0;
    check("done_busy", 64'(busy), 64'd1);
    check("done_chal", puf_challenge, 64'h1F);

    // Handshake with start asserted: ignored on the handshake edge, taken next
    @(negedge clk);
    resp_ready = 1'b1;
    start      = 1'b1;
    seed       = 64'h3F0;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("hs_valid", 64'(resp_valid), 64'd0);
    check("hs_busy", 64'(busy), 64'd0);
    check("hs_data", 64'(resp_data), 64'(cur_exp));
    check("idle_chal", puf_challenge, 64'h1F);
    @(posedge clk);
    #1;
    start = 1'b0;
    seed  = 64'hDEAD;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_chal", puf_challenge, 64'h3F0);

    // Transition: challenge steps, ignored start and early ready mid-run
    exp_q.push_back(32'hFFFF_0000);
    wait_valid(64'h3F0, 1'b1, 1'b1, cyc);
    check("latency_trans", 64'(cyc), 64'(RUN_CYC));
    check_result();
    handshake();

    // Wrap-around of the challenge counter
    exp_q.push_back(32'h0000_0001);
    do_start(64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, cyc);
    check("latency_wrap", 64'(cyc), 64'(RUN_CYC));
    check_result();
    check("wrap_chal", puf_challenge, 64'd30);
    handshake();

    // Majority vote with scripted samples; non-sample cycles are random noise
    stub_mode = 1'b1;
    exp_q.push_back(32'h5555_5555);
    do_start(64'h0);
    for (int n = 1; n <= RUN_CYC; n++) begin
      m = (n - 1) % 10;
      k = (n - 1) / 10;
      if (m >= 4 && m <= 8) begin
        pat      = (k % 2 == 0) ? 5'b01011 : 5'b01010;
        stub_bit = pat[m-4];
      end else begin
        stub_bit = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
    end
    check("vote_valid", 64'(resp_valid), 64'd1);
    check_result();
    handshake();
    stub_mode = 1'b0;

    // Reset mid-run aborts, then a fresh run completes normally
    do_start(64'h400);
    repeat (99) @(posedge clk);
    #1;
    check("pre_rst_data", 64'(resp_data), 64'h1FF);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_data", 64'(resp_data), 64'd0);
    check("mid_rst_chal", puf_challenge, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'hFFFF_0000);
    do_start(64'h3F0);
    wait_valid(64'h3F0, 1'b1, 1'b0, cyc);
    check("latency_post_rst", 64'(cyc), 64'(RUN_CYC));
    check_result();
    handshake();

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Sequencer that turns one seed challenge into an N_RESP-bit response word by driving a series of challenges into a single-bit arbiter PUF. For each bit it waits a settle window, takes N_VOTE response samples and keeps the majority. It sits between the host-side request logic and the PUF instance, and owns the PUF challenge bus exclusively.

## Interface

**Parameters**
- N_CB, 64: challenge width in bits, matching the PUF.
- N_RESP, 32: response bits per request; 1..1024.
- SETTLE, 4: cycles each new challenge is held before sampling starts; ≥1.
- N_VOTE, 5: samples per bit; odd, ≥1.

**Ports** (clock and reset first)
- clk, in, 1: single clock; all logic is rising-edge.
- rst_n, in, 1: synchronous, active-low reset.
- start, in, 1: request pulse; accepted only in IDLE.
- seed, in, N_CB: first challenge; captured on the accepting edge.
- busy, out, 1: high in every state except IDLE.
- puf_challenge, out, N_CB: challenge driven to the PUF, registered.
- puf_response, in, 1: PUF response bit.
- resp_data, out, N_RESP: result word.
- resp_valid, out, 1: result available.
- resp_ready, in, 1: consumer accepts the result.

## Operation

**Reset**
- rst_n low at a rising edge sets: state=IDLE, busy=0, resp_valid=0, resp_data=0, puf_challenge=0, and all counters to 0.

**Challenge sequence**
- Bit k (k = 0..N_RESP-1) uses challenge seed+k, computed modulo 2^N_CB (wraps).
- The majority result for bit k is written to resp_data[k].

**States**
- IDLE: start=1 → capture seed into puf_challenge, clear resp_data, clear k, clear settle counter → APPLY.
- APPLY: holds puf_challenge for SETTLE cycles. Settle counter runs 0..SETTLE-1; on the last count → SAMPLE, clear the ones counter.
- SAMPLE: N_VOTE cycles. Each cycle the ones counter is incremented if puf_response=1. Ones counter width is clog2(N_VOTE+1). After the N_VOTE-th sample → COMMIT.
- COMMIT: one cycle.
  - resp_data[k] = (ones > N_VOTE/2), using integer division.
  - If k = N_RESP-1 → DONE.
  - Otherwise k=k+1, puf_challenge=puf_challenge+1, clear settle counter → APPLY.
- DONE: resp_valid=1. resp_valid && resp_ready at an edge → resp_valid=0, state IDLE.

**Boundary conditions**
- start outside IDLE, including in the DONE handshake cycle: ignored, no queueing.
- resp_ready while resp_valid=0: no effect.
- resp_data stays stable from DONE entry until the next accepted start, including after the handshake.
- puf_challenge holds its last value in DONE and IDLE.
- seed changes after capture have no effect.
- Reset mid-operation aborts immediately: no partial resp_valid, and the register values listed under Reset apply.

## Timing

- Start accepted at edge E0 → puf_challenge=seed and busy=1 visible after E0.
- Per-bit cost: SETTLE + N_VOTE + 1 cycles.
- resp_valid rises after edge E0 + N_RESP·(SETTLE+N_VOTE+1). With defaults this is 320 cycles.
- The first response sample is taken at edge E0+SETTLE+1, i.e. the challenge has been stable for SETTLE full cycles.
- resp_valid falls on the edge where resp_ready=1 is seen. busy falls on the same edge.
- Earliest next start is accepted one edge after the handshake.
- Back-to-back throughput: one result every N_RESP·(S+V+1)+2 cycles, given resp_ready=1 and start held high.

## Test plan

All scenarios use a behavioural PUF with response = challenge[10] unless noted.

- **Basic**: seed=0x0, defaults → resp_data=0x00000000. resp_valid rises exactly 320 cycles after the start edge.
- **Transition and challenge steps**: seed=0x3F0 → resp_data=0xFFFF0000. puf_challenge steps 0x3F0..0x40F, one step per 10 cycles.
- **Wrap-around**: seed=0xFFFF_FFFF_FFFF_FFFF → resp_data=0x00000001 (k=0 has bit10=1; later challenges wrap to 0..30).
- **Majority vote**: stub PUF driving, per bit, the sample pattern 1,1,0,1,0 for even k and 0,1,0,1,0 for odd k → resp_data=0x55555555.
- **Backpressure and busy**:
  - Hold resp_ready=0 for 50 cycles after valid → resp_valid and resp_data stay stable.
  - A start pulse while busy is ignored.
  - Assert ready → valid drops on that edge, and the next start is accepted one cycle later.
- **Reset mid-run**: assert rst_n=0 at cycle 100 after start → next cycle busy=0, resp_valid=0, resp_data=0, puf_challenge=0. A fresh start with seed=0x3F0 then yields 0xFFFF0000.
